// File: rtl/led_alarm_ctrl.sv
// Red-LED blink scheduler for the detonator's three alarm sources.
// Latches request pulses, serves them by fixed priority and only switches on whole-blink boundaries.
module led_alarm_ctrl #(
  parameter int HALF_PERIOD  = 62_500_000,
  parameter int WRONG_BLINKS = 3,
  parameter int WARN_BLINKS  = 1,
  parameter int GAP_HALVES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_warn,
  input  logic       req_wrong,
  input  logic       req_det,
  input  logic       clr_det,
  output logic       led_en,
  output logic       busy,
  output logic [1:0] active,
  output logic       done
);

  localparam int HPW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [HPW-1:0] HP_LAST   = HPW'(HALF_PERIOD - 1);
  localparam logic [4:0]     WRONG_LEN = 5'(2 * WRONG_BLINKS);
  localparam logic [4:0]     WARN_LEN  = 5'(2 * WARN_BLINKS);
  localparam logic [4:0]     GAP_LEN   = 5'(GAP_HALVES);

  localparam logic [1:0] ACT_NONE  = 2'd0;
  localparam logic [1:0] ACT_WARN  = 2'd1;
  localparam logic [1:0] ACT_WRONG = 2'd2;
  localparam logic [1:0] ACT_DET   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t         state_r;
  logic [HPW-1:0] hp_cnt_r;
  logic [4:0]     half_cnt_r;
  logic [4:0]     gap_cnt_r;
  logic [4:0]     burst_len_r;
  logic           pend_warn_r;
  logic           pend_wrong_r;
  logic           pend_det_r;
  logic           stop_r;

  logic           hp_wrap_s;
  logic [4:0]     half_nxt_s;
  logic [4:0]     gap_nxt_s;
  logic           run_s;
  logic           det_avail_s;
  logic           serve_warn_s;
  logic           serve_wrong_s;
  logic           serve_det_s;
  logic           boundary_s;
  logic           higher_s;
  logic           preempt_s;
  logic           det_end_s;
  logic           burst_end_s;
  logic [1:0]     sel_s;
  logic           take_s;
  logic           pend_warn_nxt_s;
  logic           pend_wrong_nxt_s;
  logic           pend_det_nxt_s;

  // Boundary detection, arbitration and next pending-latch values.
  always_comb begin
    hp_wrap_s     = (hp_cnt_r == HP_LAST);
    half_nxt_s    = half_cnt_r + 5'd1;
    gap_nxt_s     = gap_cnt_r + 5'd1;
    run_s         = (state_r == ST_RUN);
    det_avail_s   = pend_det_r & ~clr_det;
    serve_warn_s  = run_s && (active == ACT_WARN);
    serve_wrong_s = run_s && (active == ACT_WRONG);
    serve_det_s   = run_s && (active == ACT_DET);
    // An even half count after the wrap means a full blink has just finished.
    boundary_s    = run_s && hp_wrap_s && !half_nxt_s[0];

    case (active)
      ACT_WARN:  higher_s = pend_wrong_r | det_avail_s;
      ACT_WRONG: higher_s = det_avail_s;
      default:   higher_s = 1'b0;
    endcase

    preempt_s   = boundary_s && higher_s;
    det_end_s   = boundary_s && serve_det_s && (stop_r || clr_det);
    burst_end_s = run_s && hp_wrap_s && !serve_det_s && (half_nxt_s == burst_len_r) && !preempt_s;

    if (det_avail_s) begin
      sel_s = ACT_DET;
    end else if (pend_wrong_r) begin
      sel_s = ACT_WRONG;
    end else if (pend_warn_r) begin
      sel_s = ACT_WARN;
    end else begin
      sel_s = ACT_NONE;
    end
    take_s = (state_r == ST_IDLE) && (sel_s != ACT_NONE);

    pend_warn_nxt_s  = ((pend_warn_r | (req_warn & ~serve_warn_s)) & ~(take_s && (sel_s == ACT_WARN)))
                       | (preempt_s && (active == ACT_WARN));
    pend_wrong_nxt_s = ((pend_wrong_r | (req_wrong & ~serve_wrong_s)) & ~(take_s && (sel_s == ACT_WRONG)))
                       | (preempt_s && (active == ACT_WRONG));
    pend_det_nxt_s   = (pend_det_r | (req_det & ~serve_det_s)) & ~clr_det & ~(take_s && (sel_s == ACT_DET));
  end

  // Alarm FSM with registered LED enable and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      hp_cnt_r     <= '0;
      half_cnt_r   <= 5'd0;
      gap_cnt_r    <= 5'd0;
      burst_len_r  <= 5'd0;
      pend_warn_r  <= 1'b0;
      pend_wrong_r <= 1'b0;
      pend_det_r   <= 1'b0;
      stop_r       <= 1'b0;
      led_en       <= 1'b0;
      busy         <= 1'b0;
      active       <= ACT_NONE;
      done         <= 1'b0;
    end else begin
      pend_warn_r  <= pend_warn_nxt_s;
      pend_wrong_r <= pend_wrong_nxt_s;
      pend_det_r   <= pend_det_nxt_s;
      done         <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            state_r     <= ST_RUN;
            led_en      <= 1'b1;
            busy        <= 1'b1;
            active      <= sel_s;
            hp_cnt_r    <= '0;
            half_cnt_r  <= 5'd0;
            stop_r      <= 1'b0;
            burst_len_r <= (sel_s == ACT_WRONG) ? WRONG_LEN : WARN_LEN;
          end
        end
        ST_RUN: begin
          if (preempt_s || burst_end_s || det_end_s) begin
            state_r   <= ST_GAP;
            led_en    <= 1'b0;
            active    <= ACT_NONE;
            done      <= burst_end_s | det_end_s;
            hp_cnt_r  <= '0;
            gap_cnt_r <= 5'd0;
            stop_r    <= 1'b0;
          end else begin
            hp_cnt_r <= hp_wrap_s ? '0 : hp_cnt_r + HPW'(1);
            if (hp_wrap_s) begin
              half_cnt_r <= half_nxt_s;
            end
            if (serve_det_s && clr_det) begin
              stop_r <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (hp_wrap_s) begin
            hp_cnt_r  <= '0;
            gap_cnt_r <= gap_nxt_s;
            if (gap_nxt_s == GAP_LEN) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            hp_cnt_r <= hp_cnt_r + HPW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          led_en  <= 1'b0;
          busy    <= 1'b0;
          active  <= ACT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_alarm_ctrl.sv
// Scoreboard bench for led_alarm_ctrl: a time-arithmetic reference model queues expected
// bursts, a negedge monitor measures the DUT's bursts and compares them.
module tb_led_alarm_ctrl;

  localparam int HP     = 4;
  localparam int NWRONG = 3;
  localparam int NWARN  = 1;
  localparam int GAPH   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_warn = 1'b0;
  logic       req_wrong = 1'b0;
  logic       req_det = 1'b0;
  logic       clr_det = 1'b0;
  logic       led_en;
  logic       busy;
  logic [1:0] active;
  logic       done;

  always #5 clk = ~clk;

  led_alarm_ctrl #(
    .HALF_PERIOD (HP),
    .WRONG_BLINKS(NWRONG),
    .WARN_BLINKS (NWARN),
    .GAP_HALVES  (GAPH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_warn (req_warn),
    .req_wrong(req_wrong),
    .req_det  (req_det),
    .clr_det  (clr_det),
    .led_en   (led_en),
    .busy     (busy),
    .active   (active),
    .done     (done)
  );

  typedef struct {
    int start;
    int len;
    int act;
    int done;
  } burst_t;

  burst_t exp_q[$];
  burst_t obs_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int stray    = 0;
  int cyc      = 0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  // Reference model: bursts are described by their start edge and elapsed time.
  bit [3:0] m_pend = 4'd0;
  int m_mode = 0;
  int m_cur = 0;
  int m_start = 0;
  int m_gap_end = 0;
  bit m_stop = 1'b0;

  always @(posedge clk) begin
    int c;
    int e;
    int hi;
    bit [3:0] rq;
    bit [3:0] nxt;
    bit det_ok;
    bit bnd;
    bit pre;
    bit dend;
    bit fin;
    burst_t b;
    c = cyc;
    cyc++;
    if (!rst_n) begin
      m_pend = 4'd0;
      m_mode = 0;
      m_cur  = 0;
      m_stop = 1'b0;
    end else begin
      rq = {req_det, req_wrong, req_warn, 1'b0};
      det_ok = m_pend[3] && !clr_det;
      nxt = m_pend;
      for (int a = 1; a <= 3; a++)
        if (rq[a] && !(m_mode == 1 && m_cur == a)) nxt[a] = 1'b1;
      if (clr_det) nxt[3] = 1'b0;
      if (m_mode == 0) begin
        hi = det_ok ? 3 : (m_pend[2] ? 2 : (m_pend[1] ? 1 : 0));
        if (hi != 0) begin
          nxt[hi] = 1'b0;
          m_mode  = 1;
          m_cur   = hi;
          m_start = c;
          m_stop  = 1'b0;
        end
      end else if (m_mode == 1) begin
        e    = c - m_start;
        bnd  = (e % (2 * HP) == 0);
        pre  = bnd && ((m_cur == 1 && (m_pend[2] || det_ok)) || (m_cur == 2 && det_ok));
        dend = bnd && (m_cur == 3) && (m_stop || clr_det);
        fin  = !pre && (m_cur != 3) && (e == 2 * HP * ((m_cur == 2) ? NWRONG : NWARN));
        if (pre) nxt[m_cur] = 1'b1;
        if (pre || dend || fin) begin
          b.start = m_start;
          b.len   = e;
          b.act   = m_cur;
          b.done  = (dend || fin) ? 1 : 0;
          exp_q.push_back(b);
          m_mode    = 2;
          m_gap_end = c + GAPH * HP;
        end else if (m_cur == 3 && clr_det) begin
          m_stop = 1'b1;
        end
      end else begin
        if (c == m_gap_end) m_mode = 0;
      end
      m_pend = nxt;
    end
  end

  // Monitor: measures each DUT burst and checks it against the scoreboard.
  bit in_b = 1'b0;
  int b_start = 0;
  int b_len = 0;
  int b_act = 0;

  always @(negedge clk) begin
    burst_t o;
    burst_t x;
    if (!rst_n) begin
      in_b = 1'b0;
    end else begin
      check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
      if (led_en) begin
        if (!in_b) begin
          in_b    = 1'b1;
          b_start = cyc - 1;
          b_len   = 0;
          b_act   = int'(active);
        end
        b_len++;
        if (done || int'(active) != b_act) stray++;
      end else if (in_b) begin
        in_b    = 1'b0;
        o.start = b_start;
        o.len   = b_len;
        o.act   = b_act;
        o.done  = int'(done);
        obs_q.push_back(o);
        if (exp_q.size() == 0) begin
          check("unexpected_burst", 1, 0);
        end else begin
          x = exp_q.pop_front();
          check("burst_start", o.start, x.start);
          check("burst_len", o.len, x.len);
          check("burst_active", o.act, x.act);
          check("burst_done", o.done, x.done);
        end
      end else if (done) begin
        stray++;
      end
    end
  end

  task automatic drive(input bit w, input bit wr, input bit d, input bit cl);
    @(negedge clk);
    req_warn  = w;
    req_wrong = wr;
    req_det   = d;
    clr_det   = cl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      ok = (m_mode == 0) && (m_pend == 4'd0) && !led_en && !busy;
    end
    idle(2);
    check("drain_in_budget", int'(ok), 1);
  endtask

  task automatic check_obs(input string name, input int idx, input int act, input int len, input int dn);
    if (obs_q.size() > idx) begin
      check({name, "_act"}, obs_q[idx].act, act);
      check({name, "_len"}, obs_q[idx].len, len);
      check({name, "_done"}, obs_q[idx].done, dn);
    end else begin
      check({name, "_present"}, obs_q.size(), idx + 1);
    end
  endtask

  int p;
  int base;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_led_en", int'(led_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_active", int'(active), 0);
    check("rst_done", int'(done), 0);
    #1 rst_n = 1'b1;
    idle(3);

    // Single wrong-code burst: starts one edge after the request is latched.
    base = obs_q.size();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    p = cyc;
    wait_idle(200);
    check_obs("wrong_single", base, 2, 2 * NWRONG * HP, 1);
    if (obs_q.size() > base) check("wrong_single_start", obs_q[base].start, p + 1);

    // Simultaneous warn and wrong: wrong first, warn after gap + idle cycle.
    base = obs_q.size();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle(300);
    check_obs("pair_wrong", base, 2, 24, 1);
    check_obs("pair_warn", base + 1, 1, 8, 1);
    if (obs_q.size() > base + 1)
      check("pair_spacing", obs_q[base + 1].start - obs_q[base].start, 24 + GAPH * HP + 1);

    // Warn preempted by det mid-blink; det cleared at an odd half; warn re-served.
    base = obs_q.size();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(40);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(400);
    check_obs("preempt_warn", base, 1, 8, 0);
    check_obs("det_burst", base + 1, 3, 32, 1);
    check_obs("warn_again", base + 2, 1, 8, 1);
    if (obs_q.size() > base + 1) check("det_whole_blinks", obs_q[base + 1].len % (2 * HP), 0);

    // Repeated wrong requests during its own burst are absorbed.
    base = obs_q.size();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      idle(3);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
    end
    wait_idle(300);
    check("absorb_count", obs_q.size() - base, 1);

    // Asynchronous reset mid-burst discards everything.
    base = obs_q.size();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(10);
    #1 rst_n = 1'b0;
    #1;
    check("arst_led_en", int'(led_en), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_active", int'(active), 0);
    check("arst_done", int'(done), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(80);
    check("arst_no_resume", obs_q.size() - base, 0);

    // Random request traffic against the model.
    for (int i = 0; i < 4000; i++)
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(2000);

    check("scoreboard_empty", exp_q.size(), 0);
    check("stray_done_or_active", stray, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_alarm_ctrl.md
# led_alarm_ctrl

Controller that schedules the single red-LED blinker among three alarm sources of the numeric code detonator: detonation, wrong-code entry and countdown warning. It latches one-cycle request pulses, arbitrates by fixed priority, and drives the blinker enable for a bounded number of whole blinks per alarm. It keeps a half-period counter matched to the blinker, so every enable window ends on a full-blink boundary and the LED always rests dark.

## Interface
- HALF_PERIOD, 62_500_000, clk cycles per LED half-period; must equal the blinker's toggle interval (0.5 s at 125 MHz).
- WRONG_BLINKS, 3, full blinks (on+off) per wrong-code alarm; 1..15.
- WARN_BLINKS, 1, full blinks per warning alarm; 1..15.
- GAP_HALVES, 2, dark half-periods inserted between consecutive alarm bursts; ≥1.

- clk  in  1  system clock (125 MHz).
- rst_n  in  1  reset; asynchronous assert, active-low (fixed).
- req_warn  in  1  pulse; request a warning burst (priority 0, lowest).
- req_wrong  in  1  pulse; request a wrong-code burst (priority 1).
- req_det  in  1  pulse; request continuous detonation blinking (priority 2, highest).
- clr_det  in  1  pulse; stop detonation blinking.
- led_en  out  1  registered enable to the blinker.
- busy  out  1  high in any state other than IDLE.
- active  out  2  alarm being served: 0 none, 1 warn, 2 wrong, 3 det.
- done  out  1  one-cycle pulse when a burst completes or detonation is cleared.

## Operation
- Pending latches: pend_warn, pend_wrong, pend_det. Each is set by its request pulse. A request for an already-pending or currently served alarm is absorbed, not counted. clr_det clears pend_det. clr_det wins over req_det in the same cycle.
- States:
  - IDLE: led_en=0. If any pending bit is set, select the highest-priority one, clear its pending bit, load the burst length (2*WRONG_BLINKS or 2*WARN_BLINKS half-periods; det is unbounded), and go to RUN.
  - RUN: led_en=1. hp_cnt counts 0..HALF_PERIOD-1. On wrap, half_cnt increments. The burst ends when half_cnt reaches the burst length; the state then goes to GAP, done pulses, and active goes to 0.
  - GAP: led_en=0. GAP_HALVES half-periods are counted, then the state goes to IDLE. New requests during GAP are latched only.
- Preemption: a higher-priority pending request during RUN takes effect at the next even half_cnt boundary, i.e. at the end of a full blink. The preempted alarm's pending bit is re-set, so it restarts from zero later. It goes to GAP without a done pulse.
- Detonation: RUN continues indefinitely. clr_det, or clr_det received while det is served, ends the burst at the next even half_cnt boundary, with a done pulse and then GAP. Det cannot be preempted.
- An odd toggle count is never allowed at disable, so the blinker's held phase is always dark on re-enable.
- half_cnt is 5 bits. GAP counter is 5 bits.

## Timing
- Reset values: led_en=0, busy=0, active=0, done=0, all counters and pending bits 0, state IDLE.
- Request latency: req at cycle t sets pend at t+1. IDLE leaves at t+1, so led_en=1 and active are valid at t+2.
- Burst length: led_en high for exactly 2*N*HALF_PERIOD cycles. done is asserted in the cycle after the last high cycle, coincident with led_en falling.
- Gap: led_en low for GAP_HALVES*HALF_PERIOD cycles, plus 1 IDLE cycle before the next burst.
- Preemption and clr_det are honored only at full-blink boundaries. Worst-case delay is 2*HALF_PERIOD cycles.
- Simultaneous req_* in the same cycle: all are latched; they are served in priority order.
- Asynchronous reset mid-burst: led_en drops immediately and all pending bits are lost.

## Test plan
- HALF_PERIOD=4, WRONG_BLINKS=3: one req_wrong pulse → led_en high for 24 cycles starting 2 cycles after the pulse, active=2, then done=1 for 1 cycle, then 8 dark cycles and busy low.
- req_warn and req_wrong in the same cycle → wrong burst (24 cycles), then gap (8 cycles), then warn burst (8 cycles), with two done pulses.
- req_warn, then req_det at cycle 5 of the burst (half_cnt=1) → warn runs until cycle 8 (end of blink 1), then gap, then det with active=3 and no done for warn. Warn is re-served after clr_det.
- Det running, clr_det at an odd half_cnt → led_en stays high until the next even boundary (≤8 cycles), then done; total high cycles is a multiple of 8.
- Repeated req_wrong pulses during its own burst → only one burst occurs, and there is no extra burst afterwards.
- rst_n low for 1 cycle mid-burst → led_en=0 asynchronously, all outputs at reset values, and no burst resumes after release.
